punc_fetch_unit: RTL and testbench
==================================

// Module: punc_fetch_unit
// PURPOSE
//   Instruction-fetch stage upstream of the PUnC control FSM. Owns the PC,
//   issues single-outstanding reads to instruction memory, and loads IR.
//   Delivers the instruction word plus its PC to control with a one-cycle
//   ir_valid pulse. Supports PC clear/increment/load redirects, halt and
//   memory-timeout detection.
// PARAMETERS
//   RESET_PC  16'h0000  PC value after reset and after pc_clr
//   TIMEOUT   8         max cycles in WAIT before mem_err (must be >= 1)
// PORTS
//   clk          in   1   clock
//   rst          in   1   reset, synchronous, active-high
//   fetch_req    in   1   control requests next instruction (level)
//   pc_clr       in   1   PC <= RESET_PC
//   pc_inc       in   1   PC <= PC + 1
//   pc_ld        in   1   PC <= pc_ld_data
//   pc_ld_data   in   16  redirect target
//   halt         in   1   enter HALTED (sticky until rst)
//   mem_r_en     out  1   memory read strobe, one cycle per request
//   mem_r_addr   out  16  read address (valid while mem_r_en)
//   mem_r_data   in   16  read data (valid with mem_r_valid)
//   mem_r_valid  in   1   read response, exactly one per mem_r_en, in order
//   pc           out  16  architectural PC
//   ir           out  16  instruction register
//   ir_pc        out  16  PC the current ir was fetched from
//   ir_valid     out  1   one-cycle pulse: ir/ir_pc just updated
//   busy         out  1   high in ISSUE or WAIT
//   halted       out  1   high in HALTED
//   mem_err      out  1   sticky: read exceeded TIMEOUT cycles
// BEHAVIOUR
//   Reset: state=IDLE; pc=RESET_PC; ir=0; ir_pc=0; all 1-bit outputs 0;
//     squash=0; wait counter=0. Reset mid-read: response arriving after reset
//     is ignored (IDLE ignores mem_r_valid).
//   PC update, every cycle, priority pc_clr > pc_ld > pc_inc; PC+1 wraps
//     16'hFFFF -> 16'h0000. PC updates are legal in any state except HALTED.
//   FSM:
//     IDLE:   fetch_req -> ISSUE.
//     ISSUE:  mem_r_en=1, mem_r_addr=pc (pre-update value that cycle);
//             capture addr into fetch_addr; squash<=0; clear counter -> WAIT.
//     WAIT:   counter++ each cycle. On mem_r_valid:
//               squash=0 -> ir<=mem_r_data, ir_pc<=fetch_addr -> DONE;
//               squash=1 -> drop data; fetch_req ? ISSUE : IDLE.
//             Counter reaches TIMEOUT with no response -> mem_err<=1, HALTED.
//     DONE:   ir_valid=1 for this cycle only -> IDLE. Requester must drop
//             fetch_req in the DONE cycle to avoid a back-to-back fetch.
//     HALTED: terminal until rst; mem_r_en=0; PC frozen; responses ignored.
//   Redirect squash: pc_clr or pc_ld asserted in ISSUE or WAIT sets squash;
//     the outstanding response is discarded and a fresh read of the new PC
//     follows. pc_inc alone does not squash. Redirect with mem_r_valid in the
//     same WAIT cycle: data discarded.
//   halt: from any state -> HALTED next cycle; outstanding read discarded;
//     halt has priority over mem_r_valid and fetch_req.
//   busy = (ISSUE|WAIT); halted = (state==HALTED). ir/ir_pc hold between
//     fetches.
// TESTING
//   1 rst, fetch_req=1, mem 2-cycle latency returns 16'h1234 @0 -> mem_r_en
//     once, addr 0; ir=16'h1234, ir_pc=0, ir_valid one pulse.
//   2 pc_inc x3 then fetch -> mem_r_addr=3; pc=16'hFFFF + pc_inc -> pc=0.
//   3 fetch in WAIT, pc_ld=16'h0040 -> first response dropped, second read
//     at 16'h0040, ir_pc=16'h0040, exactly one ir_valid.
//   4 Same cycle pc_clr=1, pc_ld=1 -> pc=RESET_PC.
//   5 No mem_r_valid for TIMEOUT cycles -> mem_err=1, halted=1, no ir_valid.
//   6 halt during WAIT then response -> ir unchanged, halted=1; rst -> IDLE,
//     pc=RESET_PC.

Source files
------------

// File: rtl/punc_fetch_unit.sv
// punc_fetch_unit: PUnC instruction fetch stage (PC, single-outstanding IMEM read, IR) with redirect squash, halt and read timeout
module punc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        pc_clr,
  input  logic        pc_inc,
  input  logic        pc_ld,
  input  logic [15:0] pc_ld_data,
  input  logic        halt,
  output logic        mem_r_en,
  output logic [15:0] mem_r_addr,
  input  logic [15:0] mem_r_data,
  input  logic        mem_r_valid,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  output logic        busy,
  output logic        halted,
  output logic        mem_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HALTED} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic squash;
  logic [CW-1:0] cnt;
  logic [15:0] fetch_addr;
  logic [15:0] pc_next;
  logic redirect;
  always_comb begin
    redirect = pc_clr | pc_ld;
    pc_next = pc_clr ? RESET_PC : pc_ld ? pc_ld_data : pc_inc ? pc + 16'd1 : pc;
  end
  assign mem_r_en = state == ISSUE;
  assign mem_r_addr = pc;
  assign ir_valid = state == DONE;
  assign busy = state == ISSUE || state == WAIT;
  assign halted = state == HALTED;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      ir_pc <= '0;
      mem_err <= 1'b0;
      squash <= 1'b0;
      cnt <= '0;
      fetch_addr <= '0;
    end else begin
      if (state != HALTED) pc <= pc_next;
      if (halt) state <= HALTED;
      else case (state)
        IDLE: if (fetch_req) state <= ISSUE;
        ISSUE: begin
          fetch_addr <= pc;
          squash <= redirect;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (redirect) squash <= 1'b1;
          // a redirect in the response cycle also kills the data
          if (mem_r_valid) begin
            if (squash || redirect) state <= fetch_req ? ISSUE : IDLE;
            else begin
              ir <= mem_r_data;
              ir_pc <= fetch_addr;
              state <= DONE;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            mem_err <= 1'b1;
            state <= HALTED;
          end
        end
        DONE: state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_punc_fetch_unit.sv
module tb_punc_fetch_unit;
  logic clk = 0, rst = 1, fetch_req = 0, pc_clr = 0, pc_inc = 0, pc_ld = 0, halt = 0;
  logic [15:0] pc_ld_data = 0, mem_r_data = 0;
  logic mem_r_valid = 0;
  logic mem_r_en, ir_valid, busy, halted, mem_err;
  logic [15:0] mem_r_addr, pc, ir, ir_pc;
  int total = 0, bad = 0;
  int en_cnt = 0, iv_cnt = 0, cd = 0;
  logic [15:0] last_addr = 0, pend_addr = 0;
  logic drop = 0;

  punc_fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_clr(pc_clr), .pc_inc(pc_inc),
    .pc_ld(pc_ld), .pc_ld_data(pc_ld_data), .halt(halt), .mem_r_en(mem_r_en),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data), .mem_r_valid(mem_r_valid),
    .pc(pc), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .busy(busy),
    .halted(halted), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a == 16'h0000 ? 16'h1234 : a == 16'h0003 ? 16'hA003 : a == 16'h0040 ? 16'hBEEF : 16'hDEAD;
  endfunction

  // memory model with 2-cycle latency plus event monitors, all at negedge
  always @(negedge clk) begin
    mem_r_valid = 0;
    if (rst) cd = 0;
    else if (mem_r_en) begin
      cd = 2;
      pend_addr = mem_r_addr;
      last_addr = mem_r_addr;
      en_cnt++;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && !drop) begin
        mem_r_valid = 1;
        mem_r_data = mem_word(pend_addr);
      end
    end
    if (ir_valid) iv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_iv(input string tag);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ir_valid) break;
    end
    fetch_req = 0;
    total++;
    if (k == 50) begin
      bad++;
      $error("FAIL %s_timeout observed=no_ir_valid expected=ir_valid", tag);
    end
    cyc();
  endtask

  initial begin
    cyc(2);
    rst = 0;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ir_pc", ir_pc, 16'h0000);
    chk("rst_flags", {mem_r_en, ir_valid, busy, halted, mem_err}, 5'b0);
    // 1: basic fetch
    en_cnt = 0; iv_cnt = 0;
    fetch_req = 1;
    wait_iv("t1");
    chk("t1_ir", ir, 16'h1234);
    chk("t1_ir_pc", ir_pc, 16'h0000);
    cyc(3);
    chk("t1_en_cnt", en_cnt, 1);
    chk("t1_addr", last_addr, 16'h0000);
    chk("t1_iv_cnt", iv_cnt, 1);
    chk("t1_busy", busy, 0);
    // 2: increment, fetch at 3, wrap
    pc_inc = 1;
    cyc(3);
    pc_inc = 0;
    chk("t2_pc3", pc, 16'h0003);
    fetch_req = 1;
    wait_iv("t2");
    chk("t2_addr", last_addr, 16'h0003);
    chk("t2_ir", ir, 16'hA003);
    chk("t2_ir_pc", ir_pc, 16'h0003);
    pc_ld = 1; pc_ld_data = 16'hFFFF;
    cyc();
    pc_ld = 0;
    chk("t2_pc_ffff", pc, 16'hFFFF);
    pc_inc = 1;
    cyc();
    pc_inc = 0;
    chk("t2_wrap", pc, 16'h0000);
    // 3: redirect while waiting squashes the first response
    cyc(2);
    en_cnt = 0; iv_cnt = 0;
    fetch_req = 1;
    cyc(2);
    chk("t3_in_wait", {busy, mem_r_en}, 2'b10);
    pc_ld = 1; pc_ld_data = 16'h0040;
    cyc();
    pc_ld = 0;
    wait_iv("t3");
    chk("t3_ir", ir, 16'hBEEF);
    chk("t3_ir_pc", ir_pc, 16'h0040);
    cyc(3);
    chk("t3_en_cnt", en_cnt, 2);
    chk("t3_addr", last_addr, 16'h0040);
    chk("t3_iv_cnt", iv_cnt, 1);
    // 4: clear beats load
    pc_clr = 1; pc_ld = 1; pc_ld_data = 16'h5555;
    cyc();
    pc_clr = 0; pc_ld = 0;
    chk("t4_pc", pc, 16'h0000);
    // 5: timeout
    iv_cnt = 0;
    drop = 1;
    fetch_req = 1;
    cyc(9);
    chk("t5_before", {mem_err, halted, busy}, 3'b001);
    cyc();
    chk("t5_after", {mem_err, halted, busy}, 3'b110);
    fetch_req = 0;
    pc_inc = 1;
    cyc(2);
    pc_inc = 0;
    chk("t5_pc_frozen", pc, 16'h0000);
    chk("t5_iv_cnt", iv_cnt, 0);
    drop = 0;
    rst = 1;
    cyc();
    rst = 0;
    chk("t5_rst_err", {mem_err, halted}, 2'b00);
    // 6: halt during wait, then the response arrives
    pc_ld = 1; pc_ld_data = 16'h0040;
    cyc();
    pc_ld = 0;
    fetch_req = 1;
    cyc(2);
    fetch_req = 0;
    iv_cnt = 0;
    halt = 1;
    cyc();
    halt = 0;
    cyc(4);
    chk("t6_halted", halted, 1);
    chk("t6_ir", ir, 16'h0000);
    chk("t6_iv_cnt", iv_cnt, 0);
    chk("t6_pc", pc, 16'h0040);
    rst = 1;
    cyc();
    rst = 0;
    chk("t6_rst_state", {halted, busy, mem_err}, 3'b000);
    chk("t6_rst_pc", pc, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
